// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared control-unit package: fetch widths, reset PC, fetch queue entry type
//
// Purpose: constants and types shared by the fetch stage and the control unit.
// Ports: none (package).

package cu_pkg;

  localparam int PC_WIDTH         = 7;
  localparam int INSTRUCTION_SIZE = 32;
  localparam int FETCH_DEPTH      = 4;

  localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [PC_WIDTH-1:0]         pc;
    logic [INSTRUCTION_SIZE-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush and occupancy count
//
// Purpose: in-order storage with registered entries; head visible the cycle after a push.
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   asynchronous active-low reset
//   flush      in   drop all entries (wins over a same-cycle push)
//   push       in   write push_data (ignored when full and not popping)
//   push_data  in   WIDTH-bit entry to write
//   pop        in   consume head (ignored when empty)
//   pop_data   out  head entry, zero when empty
//   count      out  number of stored entries (0..DEPTH)

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= push_data;
  end

  assign pop_data = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - sequential instruction prefetch with redirect flush
//
// Purpose: issues sequential reads to a 1-cycle-latency instruction memory, queues
// (pc, instr) pairs and presents them to the control unit over valid/ready.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   imem_req     out  read strobe
//   imem_addr    out  read word address (current fetch PC)
//   imem_rdata   in   read data, valid the cycle after imem_req
//   out_valid    out  queue head holds an instruction
//   out_ready    in   control unit accepts the head
//   out_instr    out  head instruction
//   out_pc       out  head PC
//   redirect     in   control transfer: flush and restart at redirect_pc
//   redirect_pc  in   new fetch target

module inst_prefetch
  import cu_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [PC_WIDTH-1:0]         imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTRUCTION_SIZE-1:0] out_instr,
  output logic [PC_WIDTH-1:0]         out_pc,
  input  logic                        redirect,
  input  logic [PC_WIDTH-1:0]         redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                inflight_q, inflight_d;
  logic                kill_q, kill_d;

  logic [CW-1:0]       count;
  logic [CW:0]         used;
  logic                issue, push, pop;
  fetch_entry_t        push_entry, head_entry;

  // Credit counts queued entries plus the read in flight; a same-cycle pop
  // gives no credit so the issue path never depends on out_ready.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue = rst && !redirect && (used < (CW+1)'(DEPTH));

  assign push = inflight_q && !kill_q;
  assign pop  = out_valid && out_ready;

  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    // A response already on its way when the redirect lands belongs to the old stream.
    kill_d        = redirect && inflight_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + PC_WIDTH'(1);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      kill_q        <= kill_d;
    end
  end

  // Flush outranks the push of a response arriving in the redirect cycle.
  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .count     (count)
  );

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign out_valid = (count != '0);
  assign out_instr = head_entry.instr;
  assign out_pc    = head_entry.pc;

endmodule

// File: tb/tb_inst_prefetch.sv
// tb/tb_inst_prefetch.sv - self-checking bench for inst_prefetch

module tb_inst_prefetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [6:0]  out_pc;
  logic        redirect;
  logic [6:0]  redirect_pc;

  inst_prefetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [128];

  // Memory model: request seen before the edge, data presented just after it.
  logic       mreq;
  logic [6:0] maddr;
  always begin
    @(negedge clk);
    mreq  = imem_req;
    maddr = imem_addr;
    @(posedge clk);
    #1;
    imem_rdata = mreq ? mem[maddr] : $urandom;
  end

  // Reference: the CU sees mem[pc] for pc, pc+1, ... from the last restart point.
  logic [6:0]  exp_pc;
  logic        prev_stall;
  logic [6:0]  popped [$];
  logic        last_valid, last_req;
  logic [6:0]  last_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rdy, input logic redir, input logic [6:0] rpc);
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    @(negedge clk);
    last_valid = out_valid;
    last_pc    = out_pc;
    last_req   = imem_req;
    if (prev_stall) check("hold_valid", out_valid, 1);
    if (out_valid) begin
      check("head_pc", out_pc, exp_pc);
      check("head_instr", out_instr, mem[exp_pc]);
      if (out_ready) begin
        popped.push_back(out_pc);
        exp_pc = exp_pc + 7'd1;
      end
    end
    prev_stall = out_valid && !out_ready && !redirect;
    if (redirect) exp_pc = redirect_pc;
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  task automatic model_restart();
    exp_pc     = 7'd0;
    prev_stall = 1'b0;
    popped.delete();
  endtask

  task automatic check_list(input string tag, input int idx, input logic [6:0] exp);
    logic [6:0] v;
    v = (popped.size() > idx) ? popped[idx] : 7'bx;
    check(tag, v, exp);
  endtask

  int first_valid;
  int nvalid;
  int reqs;
  int fives;
  bit found;

  initial begin
    rst         = 1'b0;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rdata  = '0;
    for (int i = 0; i < 128; i++) mem[i] = i * 32'h11;
    model_restart();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    check("rst_req", imem_req, 0);

    // 1: release, stream with out_ready high
    rst = 1'b1;
    first_valid = -1;
    nvalid = 0;
    for (int k = 0; k < 24; k++) begin
      cycle(1'b1, 1'b0, 7'd0);
      if (k == 0) check("first_issue", last_req, 1);
      if (last_valid && first_valid < 0) first_valid = k;
      if (k >= 2 && last_valid) nvalid++;
    end
    check("first_valid_latency", first_valid, 2);
    check("throughput", nvalid, 22);
    check_list("stream_pc0", 0, 7'd0);
    check_list("stream_pc21", 21, 7'd21);

    // 2: stall from reset
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_restart();
    reqs = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 7'd0);
      if (last_req) reqs++;
    end
    check("stall_reads", reqs, 4);
    check("stall_req_low", last_req, 0);
    check("stall_head_valid", last_valid, 1);
    check("stall_head_pc", last_pc, 0);

    // 3: redirect with 3 queued and one read in flight
    cycle(1'b1, 1'b0, 7'd0);
    check("no_credit_from_pop", last_req, 0);
    cycle(1'b0, 1'b0, 7'd0);
    check("refill_issue", last_req, 1);
    cycle(1'b0, 1'b1, 7'h40);
    check("redirect_no_issue", last_req, 0);
    cycle(1'b1, 1'b0, 7'd0);
    check("redir_valid_1", last_valid, 0);
    cycle(1'b1, 1'b0, 7'd0);
    check("redir_valid_2", last_valid, 0);
    cycle(1'b1, 1'b0, 7'd0);
    check("redir_valid_3", last_valid, 1);
    check("redir_pc_3", last_pc, 7'h40);
    repeat (6) cycle(1'b1, 1'b0, 7'd0);

    // 4: redirect in the same cycle the head pc=5 is accepted
    cycle(1'b1, 1'b1, 7'd3);
    popped.delete();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (out_valid && out_pc == 7'd5) found = 1'b1;
      else cycle(1'b1, 1'b0, 7'd0);
    end
    check("pc5_reached", found, 1);
    cycle(1'b1, 1'b1, 7'h20);
    repeat (8) cycle(1'b1, 1'b0, 7'd0);
    fives = 0;
    foreach (popped[i]) if (popped[i] == 7'd5) fives++;
    check("pc5_once", fives, 1);
    check_list("after_pc5", 3, 7'h20);

    // 5: wrap at top of the address space
    cycle(1'b1, 1'b1, 7'd126);
    popped.delete();
    repeat (8) cycle(1'b1, 1'b0, 7'd0);
    check_list("wrap0", 0, 7'd126);
    check_list("wrap1", 1, 7'd127);
    check_list("wrap2", 2, 7'd0);
    check_list("wrap3", 3, 7'd1);

    // 6: asynchronous reset mid-stream
    #3;
    rst = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_pc", out_pc, 0);
    check("async_instr", out_instr, 0);
    check("async_req", imem_req, 0);
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_restart();
    first_valid = -1;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, 7'd0);
      if (last_valid && first_valid < 0) first_valid = k;
    end
    check("restart_latency", first_valid, 2);
    check_list("restart_pc0", 0, 7'd0);

    // Random traffic against the reference
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(3) != 0), ($urandom_range(15) == 0), 7'($urandom_range(127)));
    end
    repeat (8) cycle(1'b1, 1'b0, 7'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
